// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexing scan controller for a multi-digit
// seven-segment display. It shares one active-low cathode bus among DIGITS
// active-low anodes. Each digit slot has a blank dead-time followed by a
// brightness-scaled on-time and an off remainder. The block also provides
// tear-free frame-boundary loading, per-digit blinking and a frame strobe.
//
// Ports:
//   clk          single clock
//   rst          asynchronous, active-low reset
//   display      per-digit cathode bytes; digit i is [i*8 +: 8], pin polarity
//   load         request to capture display at the next frame boundary
//   enable       scanning enable; low forces blank/IDLE on the next cycle
//   brightness   duty level 0..7, sampled at each slot start
//   blink_mask   1 blinks the corresponding digit
//   anode        active-low digit enables (at most one low)
//   cathode      active-low segments
//   digit_idx    index of the digit whose slot is current
//   frame_start  one-cycle pulse in the first cycle of the digit-0 slot

package types_pkg;
  localparam int unsigned DIGITS = 8;
endpackage

module seg_scan_ctrl #(
  parameter int unsigned DIGITS       = types_pkg::DIGITS,
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned DEAD_CYCLES  = 64,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGITS*8-1:0]       display,
  input  logic                      load,
  input  logic                      enable,
  input  logic [2:0]                brightness,
  input  logic [DIGITS-1:0]         blink_mask,
  output logic [DIGITS-1:0]         anode,
  output logic [7:0]                cathode,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_start
);

  localparam int unsigned DW      = $clog2(DIGITS);
  localparam int unsigned CW      = $clog2(REFRESH_DIV);
  localparam int unsigned TW      = CW + 1;
  localparam int unsigned FW      = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned ON_UNIT = (REFRESH_DIV - DEAD_CYCLES) >> 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2,
    OFF  = 2'd3
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [DW-1:0]            digit_n;
  logic [TW-1:0]            on_q, on_n;
  logic                     pending, pending_n;
  logic                     blink, blink_n;
  logic [FW-1:0]            fcnt, fcnt_n;
  logic [DIGITS-1:0][7:0]   shadow;
  logic [DIGITS-1:0][7:0]   disp_v;
  logic                     shadow_ld;
  logic [DIGITS-1:0]        anode_n;
  logic [7:0]               cathode_n;
  logic                     fs_n;

  assign disp_v = display;

  function automatic logic [TW-1:0] on_calc(input logic [2:0] b);
    return TW'(ON_UNIT) * (TW'(b) + TW'(1));
  endfunction

  // Phase within a slot is a pure function of the slot cycle and on-time,
  // so the slot length stays exactly REFRESH_DIV regardless of brightness.
  function automatic state_t phase_of(input logic [TW-1:0] c,
                                      input logic [TW-1:0] on);
    if (c < TW'(DEAD_CYCLES))
      return DEAD;
    else if (c < TW'(DEAD_CYCLES) + on)
      return ON;
    return OFF;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    digit_n   = digit_idx;
    on_n      = on_q;
    pending_n = pending | load;
    blink_n   = blink;
    fcnt_n    = fcnt;
    shadow_ld = 1'b0;

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      digit_n = '0;
    end else if (state == IDLE) begin
      cnt_n     = '0;
      digit_n   = '0;
      on_n      = on_calc(brightness);
      shadow_ld = 1'b1;
      pending_n = 1'b0;
      state_n   = phase_of('0, on_n);
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt_n = '0;
      on_n  = on_calc(brightness);
      if (digit_idx == DW'(DIGITS - 1)) begin
        digit_n = '0;
        // Frame boundary: a load on this very edge counts as pending.
        if (pending || load) begin
          shadow_ld = 1'b1;
          pending_n = 1'b0;
        end
        if (fcnt == FW'(BLINK_FRAMES - 1)) begin
          fcnt_n  = '0;
          blink_n = ~blink;
        end else begin
          fcnt_n = fcnt + FW'(1);
        end
      end else begin
        digit_n = digit_idx + DW'(1);
      end
      state_n = phase_of('0, on_n);
    end else begin
      cnt_n   = cnt + CW'(1);
      state_n = phase_of({1'b0, cnt_n}, on_q);
    end

    // Outputs are derived from the next state so that the registered pins
    // line up cycle-for-cycle with the state register.
    anode_n   = '1;
    cathode_n = '1;
    fs_n      = (state_n != IDLE) && (cnt_n == '0) && (digit_n == '0);
    if (state_n == ON) begin
      cathode_n = shadow_ld ? disp_v[digit_n] : shadow[digit_n];
      if (!(blink_n && blink_mask[digit_n]))
        anode_n[digit_n] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      digit_idx   <= '0;
      on_q        <= '0;
      pending     <= 1'b0;
      blink       <= 1'b0;
      fcnt        <= '0;
      shadow      <= '1;
      anode       <= '1;
      cathode     <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      digit_idx   <= digit_n;
      on_q        <= on_n;
      pending     <= pending_n;
      blink       <= blink_n;
      fcnt        <= fcnt_n;
      if (shadow_ld)
        shadow <= disp_v;
      anode       <= anode_n;
      cathode     <= cathode_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with REFRESH_DIV=20, DEAD_CYCLES=4,
// DIGITS=8, BLINK_FRAMES=2 (slot 20 cycles, frame 160 cycles).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] display;
  logic        load;
  logic        enable;
  logic [2:0]  brightness;
  logic [7:0]  blink_mask;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [2:0]  digit_idx;
  logic        frame_start;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] base_disp;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(8),
    .REFRESH_DIV(20),
    .DEAD_CYCLES(4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .display(display),
    .load(load),
    .enable(enable),
    .brightness(brightness),
    .blink_mask(blink_mask),
    .anode(anode),
    .cathode(cathode),
    .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  typedef struct {
    logic [2:0]  br;
    logic [7:0]  mask;
    int          k;
    logic [7:0]  an;
    logic [7:0]  ca;
    logic [2:0]  idx;
    logic        fs;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reset, then enable; returns sampled in cycle 0 of frame 0.
  task automatic restart(input logic [2:0] br, input logic [7:0] mask);
    rst        = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    brightness = br;
    blink_mask = mask;
    display    = base_disp;
    tick();
    tick();
    rst    = 1'b1;
    enable = 1'b1;
    tick();
  endtask

  initial begin
    int lo0, lo1, lo0b, first0, first1;
    int blo0[6];
    int blo1[6];
    logic [7:0] pan, pca;

    for (int i = 0; i < 8; i++) base_disp[i*8 +: 8] = 8'hA0 | 8'(i);

    // {brightness, mask, cycles after first cycle, anode, cathode, idx, fs}
    vt.push_back('{3'd7, 8'h00,   0, 8'hFF, 8'hFF, 3'd0, 1'b1});
    vt.push_back('{3'd7, 8'h00,   3, 8'hFF, 8'hFF, 3'd0, 1'b0});
    vt.push_back('{3'd7, 8'h00,   4, 8'hFE, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd7, 8'h00,  19, 8'hFE, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd7, 8'h00,  20, 8'hFF, 8'hFF, 3'd1, 1'b0});
    vt.push_back('{3'd7, 8'h00,  24, 8'hFD, 8'hA1, 3'd1, 1'b0});
    vt.push_back('{3'd0, 8'h00,   5, 8'hFE, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd0, 8'h00,   6, 8'hFF, 8'hFF, 3'd0, 1'b0});
    vt.push_back('{3'd3, 8'h00, 111, 8'hDF, 8'hA5, 3'd5, 1'b0});
    vt.push_back('{3'd3, 8'h00, 112, 8'hFF, 8'hFF, 3'd5, 1'b0});
    vt.push_back('{3'd7, 8'h00, 159, 8'h7F, 8'hA7, 3'd7, 1'b0});
    vt.push_back('{3'd7, 8'h00, 160, 8'hFF, 8'hFF, 3'd0, 1'b1});
    vt.push_back('{3'd7, 8'h01, 164, 8'hFE, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd7, 8'h01, 324, 8'hFF, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd7, 8'h01, 344, 8'hFD, 8'hA1, 3'd1, 1'b0});
    vt.push_back('{3'd7, 8'h01, 644, 8'hFE, 8'hA0, 3'd0, 1'b0});
    vt.push_back('{3'd1, 8'h00,  47, 8'hFB, 8'hA2, 3'd2, 1'b0});
    vt.push_back('{3'd1, 8'h00,  48, 8'hFF, 8'hFF, 3'd2, 1'b0});
    vt.push_back('{3'd4, 8'h00, 133, 8'hBF, 8'hA6, 3'd6, 1'b0});
    vt.push_back('{3'd4, 8'h00, 134, 8'hFF, 8'hFF, 3'd6, 1'b0});

    // Reset and idle
    rst = 1'b0; enable = 1'b0; load = 1'b0; brightness = 3'd7;
    blink_mask = 8'h00; display = base_disp;
    tick();
    chk8("rst_anode", anode, 8'hFF);
    chk8("rst_cathode", cathode, 8'hFF);
    chk8("rst_idx", 8'(digit_idx), 8'h00);
    chk8("rst_fs", 8'(frame_start), 8'h00);
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk8("idle_anode", anode, 8'hFF);
      chk8("idle_cathode", cathode, 8'hFF);
      chk8("idle_fs", 8'(frame_start), 8'h00);
    end

    // Table-driven vectors
    for (int i = 0; i < vt.size(); i++) begin
      restart(vt[i].br, vt[i].mask);
      repeat (vt[i].k) tick();
      chk8($sformatf("vec%0d_anode", i), anode, vt[i].an);
      chk8($sformatf("vec%0d_cathode", i), cathode, vt[i].ca);
      chk8($sformatf("vec%0d_idx", i), 8'(digit_idx), 8'(vt[i].idx));
      chk8($sformatf("vec%0d_fs", i), 8'(frame_start), 8'(vt[i].fs));
    end

    // Duty cycle and frame strobe period
    restart(3'd7, 8'h00);
    lo0 = 0; lo1 = 0; lo0b = 0; first0 = -1; first1 = -1;
    for (int k = 0; k < 480; k++) begin
      chk8($sformatf("duty_fs_k%0d", k), 8'(frame_start), (k % 160 == 0) ? 8'h01 : 8'h00);
      if (k < 20 && !anode[0]) begin
        lo0++;
        if (first0 < 0) first0 = k;
      end
      if (k >= 20 && k < 40 && !anode[1]) begin
        lo1++;
        if (first1 < 0) first1 = k - 20;
      end
      if (k >= 160 && k < 180 && !anode[0]) lo0b++;
      if (k == 19) brightness = 3'd0;
      tick();
    end
    chki("duty_b7_len", lo0, 16);
    chki("duty_b7_start", first0, 4);
    chki("duty_b0_len", lo1, 2);
    chki("duty_b0_start", first1, 4);
    chki("duty_b0_next_frame", lo0b, 2);

    // Frame-boundary load
    restart(3'd7, 8'h00);
    for (int k = 0; k <= 710; k++) begin
      case (k)
        50:  begin display[31:24] = 8'hBF; load = 1'b1; end
        51:  load = 1'b0;
        70:  begin chk8("load_old_cath", cathode, 8'hA3); chk8("load_old_an", anode, 8'hF7); end
        100: display[31:24] = 8'hC0;
        164: begin chk8("load_d0_cath", cathode, 8'hA0); chk8("load_d0_an", anode, 8'hFE); end
        224: begin chk8("load_new_cath", cathode, 8'hC0); chk8("load_new_an", anode, 8'hF7); end
        319: begin display[31:24] = 8'h5A; load = 1'b1; end
        320: load = 1'b0;
        330: begin display[31:24] = 8'h77; load = 1'b1; end
        331: load = 1'b0;
        340: display[31:24] = 8'h66;
        350: load = 1'b1;
        351: load = 1'b0;
        384: begin chk8("load_edge_cath", cathode, 8'h5A); chk8("load_edge_an", anode, 8'hF7); end
        500: display[31:24] = 8'h99;
        544: chk8("load_collapse_cath", cathode, 8'h66);
        704: chk8("load_no_pending_cath", cathode, 8'h66);
        default: ;
      endcase
      tick();
    end

    // Blink
    restart(3'd7, 8'h01);
    for (int f = 0; f < 6; f++) begin
      blo0[f] = 0;
      blo1[f] = 0;
    end
    for (int k = 0; k < 960; k++) begin
      if ((k % 160) < 20 && !anode[0]) blo0[k / 160]++;
      if ((k % 160) >= 20 && (k % 160) < 40 && !anode[1]) blo1[k / 160]++;
      tick();
    end
    for (int f = 0; f < 6; f++) begin
      chki($sformatf("blink_d0_frame%0d", f), blo0[f], (f == 2 || f == 3) ? 0 : 16);
      chki($sformatf("blink_d1_frame%0d", f), blo1[f], 16);
    end

    // Disable during ON of digit 5, then re-enable
    restart(3'd7, 8'h00);
    repeat (105) tick();
    chk8("dis_before_an", anode, 8'hDF);
    chk8("dis_before_cath", cathode, 8'hA5);
    enable = 1'b0;
    tick();
    chk8("dis_an", anode, 8'hFF);
    chk8("dis_cath", cathode, 8'hFF);
    chk8("dis_idx", 8'(digit_idx), 8'h00);
    chk8("dis_fs", 8'(frame_start), 8'h00);
    repeat (3) tick();
    chk8("dis_idle_fs", 8'(frame_start), 8'h00);
    enable = 1'b1;
    tick();
    chk8("reen_fs", 8'(frame_start), 8'h01);
    chk8("reen_idx", 8'(digit_idx), 8'h00);
    chk8("reen_an", anode, 8'hFF);
    repeat (4) tick();
    chk8("reen_on_an", anode, 8'hFE);
    chk8("reen_on_cath", cathode, 8'hA0);

    // Asynchronous reset mid-slot, no clock edge in between
    #3 rst = 1'b0;
    #1;
    chk8("arst_an", anode, 8'hFF);
    chk8("arst_cath", cathode, 8'hFF);
    chk8("arst_idx", 8'(digit_idx), 8'h00);
    restart(3'd7, 8'h00);
    repeat (25) tick();
    chk8("arst2_idx_before", 8'(digit_idx), 8'h01);
    #3 rst = 1'b0;
    #1;
    chk8("arst2_idx", 8'(digit_idx), 8'h00);
    chk8("arst2_an", anode, 8'hFF);
    restart(3'd7, 8'h00);
    chk8("arst3_fs_before", 8'(frame_start), 8'h01);
    #3 rst = 1'b0;
    #1;
    chk8("arst3_fs", 8'(frame_start), 8'h00);

    // Random no-overlap run
    tick();
    rst = 1'b1;
    enable = 1'b1;
    pan = anode;
    pca = cathode;
    for (int c = 0; c < 10000; c++) begin
      display    = {$urandom, $urandom};
      brightness = 3'($urandom_range(0, 7));
      load       = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 199) != 0);
      if (c % 500 == 0) blink_mask = 8'($urandom_range(0, 255));
      tick();
      chki("scan_single_anode", ($countones(~anode) <= 1) ? 1 : 0, 1);
      if (anode != 8'hFF)
        chk8("scan_anode_idx", ~anode, 8'(8'd1 << digit_idx));
      if (anode != 8'hFF && pan != 8'hFF)
        chk8("scan_cath_hold", cathode, pca);
      pan = anode;
      pca = cathode;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
